// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle CPU datapath.
// Services single-word read/write requests after LATENCY cycles, decoding the
// captured word address to an internal RAM, one memory-mapped I/O word, or an
// unmapped region.
//
// Ports:
//   clk    - system clock, all state on rising edge
//   reset  - asynchronous active-low reset
//   req    - request strobe, sampled only while busy is low
//   we     - 1 = write, 0 = read (sampled with req)
//   addr   - word address (sampled with req)
//   wdata  - write data (sampled with req)
//   rdata  - read data, valid in the ack cycle, held until the next ack
//   ack    - one-cycle completion pulse
//   err    - one-cycle pulse with ack for an unmapped address
//   busy   - high while a request is in flight
//   ioIn   - asynchronous board input word
//   ioOut  - memory-mapped output register
//
// state  | meaning
// -------+----------------------------------------------
// S_IDLE | waiting for req, request registers free
// S_WAIT | wait states counting down
// S_RESP | ack cycle; access was performed on entry

module mem_responder #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    LATENCY    = 2,
    parameter logic [DATA_WIDTH-1:0] IO_ADDR    = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack,
    output logic                  err,
    output logic                  busy,
    input  logic [DATA_WIDTH-1:0] ioIn,
    output logic [DATA_WIDTH-1:0] ioOut
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   io_out_q;
    logic [DATA_WIDTH-1:0]   io_s1_q, io_s2_q;
    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    logic                    accept;
    logic                    enter_resp;
    logic                    eff_we;
    logic [DATA_WIDTH-1:0]   eff_addr;
    logic [DATA_WIDTH-1:0]   eff_wdata;
    logic                    ram_hit;
    logic                    io_hit;
    logic [ADDR_WIDTH-1:0]   ram_idx;

    assign accept = (state_q == S_IDLE) && req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // With LATENCY=1 the access happens on the accepting edge itself, before
    // the request registers hold anything, so the live inputs are used then.
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    assign eff_we     = accept ? we    : we_q;
    assign eff_addr   = accept ? addr  : addr_q;
    assign eff_wdata  = accept ? wdata : wdata_q;

    assign io_hit  = (eff_addr == IO_ADDR);
    assign ram_hit = (eff_addr[DATA_WIDTH-1:ADDR_WIDTH] == '0) && !io_hit;
    assign ram_idx = eff_addr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            io_out_q <= '0;
            io_s1_q  <= '0;
            io_s2_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            io_s1_q <= ioIn;
            io_s2_q <= io_s1_q;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (enter_resp) begin
                err_q <= !io_hit && !ram_hit;
                if (!eff_we) begin
                    if (io_hit) begin
                        rdata_q <= io_s2_q;
                    end else if (ram_hit) begin
                        rdata_q <= mem[ram_idx];
                    end else begin
                        rdata_q <= '0;
                    end
                end else if (io_hit) begin
                    io_out_q <= eff_wdata;
                end
            end else begin
                err_q <= 1'b0;
            end
        end
    end

    // RAM has no reset; the reset term only blocks a commit while reset is held.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && eff_we && ram_hit) begin
            mem[ram_idx] <= eff_wdata;
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;
    assign ioOut = io_out_q;
    assign ack   = (state_q == S_RESP);
    assign busy  = (state_q != S_IDLE);

endmodule
